// File: rtl/merge_ctrl_pkg.sv
// Shared constants and state encoding for the serial-to-nibble controller.
package merge_ctrl_pkg;
    localparam int NIBBLE_W        = 4;
    localparam int BITS_PER_NIBBLE = 4;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;
endpackage

// File: rtl/merge_bits.sv
// Combinational datapath: packs four single bits into one nibble {bitD,bitC,bitB,bitA}.
module merge_bits (
    input  logic       bitA,
    input  logic       bitB,
    input  logic       bitC,
    input  logic       bitD,
    output logic [3:0] merged_output
);
    assign merged_output = {bitD, bitC, bitB, bitA};
endmodule

// File: rtl/merge_bits_ctrl.sv
// Collects a valid/ready bit stream into nibbles via merge_bits, with
// partial-nibble timeout, flush and a delivered-nibble counter.
module merge_bits_ctrl
    import merge_ctrl_pkg::*;
#(
    parameter int MSB_FIRST = 0,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_in,
    input  logic                bit_valid,
    output logic                bit_ready,
    input  logic                flush,
    output logic [NIBBLE_W-1:0] nibble_out,
    output logic                nibble_valid,
    input  logic                nibble_ready,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    nibble_count
);
    localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t                        state_reg, state_next;
    logic [1:0]                    idx_reg, idx_next;
    logic [BITS_PER_NIBBLE-1:0]    staging_reg, staging_next;
    logic [TIMER_W-1:0]            timer_reg, timer_next;
    logic [NIBBLE_W-1:0]           nibble_out_reg, nibble_out_next;
    logic                          nibble_valid_reg, nibble_valid_next;
    logic                          timeout_err_reg, timeout_err_next;
    logic [CNT_W-1:0]              count_reg, count_next;

    logic                          accept;
    logic                          deliver;
    logic                          last_bit;
    logic                          timeout_hit;
    logic [1:0]                    pos;
    logic [BITS_PER_NIBBLE-1:0]    staged;
    logic [NIBBLE_W-1:0]           merged;

    // Stall only when a finished nibble is waiting and the consumer refuses it.
    assign bit_ready   = !rst && !(nibble_valid_reg && !nibble_ready);
    assign accept      = bit_valid && bit_ready;
    assign deliver     = nibble_valid_reg && nibble_ready;
    assign pos         = (MSB_FIRST != 0) ? (2'(3) - idx_reg) : idx_reg;
    assign last_bit    = accept && (idx_reg == 2'(BITS_PER_NIBBLE - 1));
    assign timeout_hit = (TIMEOUT != 0) && (state_reg == COLLECT) &&
                         (timer_reg == TIMER_W'(TIMEOUT));

    // Staging with the incoming bit already applied, so the 4th bit merges in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_NIBBLE; gi++) begin : g_stage
            assign staged[gi] = (accept && (pos == 2'(gi))) ? bit_in : staging_reg[gi];
        end
    endgenerate

    merge_bits u_merge (
        .bitA          (staged[0]),
        .bitB          (staged[1]),
        .bitC          (staged[2]),
        .bitD          (staged[3]),
        .merged_output (merged)
    );

    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        staging_next      = staging_reg;
        timer_next        = timer_reg;
        nibble_out_next   = nibble_out_reg;
        nibble_valid_next = nibble_valid_reg;
        timeout_err_next  = 1'b0;
        count_next        = deliver ? (count_reg + CNT_W'(1)) : count_reg;

        if (deliver) begin
            nibble_valid_next = 1'b0;
        end

        if (flush) begin
            state_next   = IDLE;
            idx_next     = 2'd0;
            staging_next = '0;
            timer_next   = '0;
        end else if (timeout_hit) begin
            state_next       = IDLE;
            idx_next         = 2'd0;
            staging_next     = '0;
            timer_next       = '0;
            timeout_err_next = 1'b1;
        end else if (accept) begin
            timer_next = '0;
            if (last_bit) begin
                state_next        = IDLE;
                idx_next          = 2'd0;
                staging_next      = '0;
                nibble_out_next   = merged;
                nibble_valid_next = 1'b1;
            end else begin
                state_next   = COLLECT;
                idx_next     = idx_reg + 2'd1;
                staging_next = staged;
            end
        end else if ((TIMEOUT != 0) && (state_reg == COLLECT) && bit_ready) begin
            timer_next = timer_reg + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            idx_reg          <= 2'd0;
            staging_reg      <= '0;
            timer_reg        <= '0;
            nibble_out_reg   <= '0;
            nibble_valid_reg <= 1'b0;
            timeout_err_reg  <= 1'b0;
            count_reg        <= '0;
        end else begin
            state_reg        <= state_next;
            idx_reg          <= idx_next;
            staging_reg      <= staging_next;
            timer_reg        <= timer_next;
            nibble_out_reg   <= nibble_out_next;
            nibble_valid_reg <= nibble_valid_next;
            timeout_err_reg  <= timeout_err_next;
            count_reg        <= count_next;
        end
    end

    assign nibble_out   = nibble_out_reg;
    assign nibble_valid = nibble_valid_reg;
    assign timeout_err  = timeout_err_reg;
    assign nibble_count = count_reg;
endmodule

// File: tb/tb_merge_bits_ctrl.sv
// Scoreboard bench: two controllers (LSB-first and MSB-first) share one stimulus stream.
module tb_merge_bits_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       flush = 1'b0;
    logic       nibble_ready = 1'b0;

    logic       bit_ready0, bit_ready1;
    logic [3:0] nibble_out0, nibble_out1;
    logic       nibble_valid0, nibble_valid1;
    logic       timeout_err0, timeout_err1;
    logic [3:0] nibble_count0, nibble_count1;

    int checks = 0;
    int failures = 0;
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    always #5 clk = ~clk;

    merge_bits_ctrl #(.MSB_FIRST(0), .TIMEOUT(8), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready0), .flush(flush), .nibble_out(nibble_out0),
        .nibble_valid(nibble_valid0), .nibble_ready(nibble_ready),
        .timeout_err(timeout_err0), .nibble_count(nibble_count0)
    );

    merge_bits_ctrl #(.MSB_FIRST(1), .TIMEOUT(8), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready1), .flush(flush), .nibble_out(nibble_out1),
        .nibble_valid(nibble_valid1), .nibble_ready(nibble_ready),
        .timeout_err(timeout_err1), .nibble_count(nibble_count1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    task automatic push(input logic [3:0] e0, input logic [3:0] e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    // Offer one bit and return just after the edge on which it was accepted.
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        bit_in = b;
        bit_valid = 1'b1;
        @(negedge clk);
        while (!bit_ready0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bit_ready0) begin
            checks++;
            failures++;
            $display("FAIL send_bit_wait actual=stalled required=accepted at %0t", $time);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake pops the scoreboard and checks the count.
    always @(negedge clk) begin
        logic [3:0] e;
        if (rst) begin
            q0.delete();
            q1.delete();
            exp_cnt0 = 0;
            exp_cnt1 = 0;
        end else begin
            if (nibble_valid0 && nibble_ready) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_nibble0 actual=%b required=none", nibble_out0);
                end else begin
                    e = q0.pop_front();
                    check("nibble0", 32'(nibble_out0), 32'(e));
                end
                check("count0", 32'(nibble_count0), 32'(exp_cnt0 % 16));
                exp_cnt0++;
                $display("dut0 nibble=%b count=%0d", nibble_out0, nibble_count0);
            end
            if (nibble_valid1 && nibble_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_nibble1 actual=%b required=none", nibble_out1);
                end else begin
                    e = q1.pop_front();
                    check("nibble1", 32'(nibble_out1), 32'(e));
                end
                check("count1", 32'(nibble_count1), 32'(exp_cnt1 % 16));
                exp_cnt1++;
                $display("dut1 nibble=%b count=%0d", nibble_out1, nibble_count1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1;
        logic [3:0] v;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bit_ready", 32'(bit_ready0), 0);
        check("rst_valid", 32'(nibble_valid0), 0);
        check("rst_out", 32'(nibble_out0), 0);
        check("rst_terr", 32'(timeout_err0), 0);
        check("rst_count", 32'(nibble_count0), 0);
        rst = 1'b0;
        nibble_ready = 1'b1;
        @(posedge clk);
        #1;

        // Bits 1,0,1,1 back to back
        push(4'b1101, 4'b1011);
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        bit_valid = 1'b0;
        check("t1_latency_valid", 32'(nibble_valid0), 1);
        check("t1_out0", 32'(nibble_out0), 32'(4'b1101));
        check("t1_out1", 32'(nibble_out1), 32'(4'b1011));
        @(posedge clk);
        #1;
        check("t1_count", 32'(nibble_count0), 1);
        check("t1_valid_drop", 32'(nibble_valid0), 0);
        idle(2);

        // Backpressure: first nibble held, fifth bit stalls
        nibble_ready = 1'b0;
        push(4'b0011, 4'b1100);
        send_bit(1); send_bit(1); send_bit(0); send_bit(0);
        check("t3_valid", 32'(nibble_valid0), 1);
        check("t3_stall", 32'(bit_ready0), 0);
        bit_in = 1'b0;
        bit_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall_hold", 32'(bit_ready0), 0);
            check("t3_out0_hold", 32'(nibble_out0), 32'(4'b0011));
            check("t3_out1_hold", 32'(nibble_out1), 32'(4'b1100));
        end
        @(posedge clk);
        #1;
        nibble_ready = 1'b1;
        push(4'b1010, 4'b0101);
        send_bit(0); send_bit(1); send_bit(0); send_bit(1);
        idle(3);
        check("t3_count", 32'(nibble_count0), 3);

        // Timeout after a 2-bit partial nibble
        send_bit(1); send_bit(1);
        bit_valid = 1'b0;
        p0 = 0;
        p1 = 0;
        repeat (20) begin
            @(negedge clk);
            if (timeout_err0) p0++;
            if (timeout_err1) p1++;
        end
        check("t4_terr_pulses0", 32'(p0), 1);
        check("t4_terr_pulses1", 32'(p1), 1);
        @(posedge clk);
        #1;
        push(4'b0110, 4'b0110);
        send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        idle(3);
        check("t4_count", 32'(nibble_count0), 4);

        // Flush together with the third bit's handshake
        send_bit(1); send_bit(0);
        flush = 1'b1;
        send_bit(1);
        flush = 1'b0;
        bit_valid = 1'b0;
        p0 = 0;
        p1 = 0;
        repeat (14) begin
            @(negedge clk);
            if (timeout_err0) p0++;
            if (timeout_err1) p1++;
        end
        check("t5_no_terr0", 32'(p0), 0);
        check("t5_no_terr1", 32'(p1), 0);
        @(posedge clk);
        #1;
        push(4'b0111, 4'b1110);
        send_bit(1); send_bit(1); send_bit(1); send_bit(0);
        idle(3);
        check("t5_count", 32'(nibble_count0), 5);

        // Reset with a pending nibble, then reset with a partial nibble
        nibble_ready = 1'b0;
        send_bit(0); send_bit(0); send_bit(0); send_bit(1);
        bit_valid = 1'b0;
        check("t6_pending", 32'(nibble_valid0), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_bit_ready", 32'(bit_ready0), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_rst_valid", 32'(nibble_valid0), 0);
        check("t6_rst_out", 32'(nibble_out0), 0);
        check("t6_rst_count", 32'(nibble_count0), 0);
        check("t6_rst_terr", 32'(timeout_err0), 0);
        nibble_ready = 1'b1;
        send_bit(1); send_bit(1);
        bit_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(4'b0001, 4'b1000);
        send_bit(1); send_bit(0); send_bit(0); send_bit(0);
        idle(3);
        check("t6_count_after", 32'(nibble_count0), 1);

        // Counter wrap: 17 nibbles from reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            v = 4'(i * 5 + 3);
            push(v, rev4(v));
            for (int k = 0; k < 4; k++) send_bit(v[k]);
        end
        idle(3);
        check("wrap_count0", 32'(nibble_count0), 1);
        check("wrap_count1", 32'(nibble_count1), 1);
        check("q0_drained", 32'(q0.size()), 0);
        check("q1_drained", 32'(q1.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
